bbs_gen_scheduler: RTL and testbench

Sequencing and arbitration controller for the Blum-Blum-Shub random-bit datapath.
- Shares one multi-cycle modular squarer (x <- x^2 mod MOD) among NREQ requesters, using round-robin arbitration.
- Runs OUT_BITS squaring iterations per granted request and shifts the LSB of each new state into a result word.
- Returns the result with a one-cycle ack to the granted requester.
- Sits between the button/flag logic and the display/number consumers; replaces free-running per-consumer generation.

---
 rtl/bbs_gen_scheduler_pkg.sv | 18 +
 rtl/bbs_gen_scheduler_if.sv | 32 +++
 rtl/bbs_mod_square_seq.sv | 70 +++++++
 rtl/bbs_gen_scheduler.sv | 151 +++++++++++++++
 tb/tb_bbs_gen_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bbs_gen_scheduler_pkg.sv
// Shared types and constants for the Blum-Blum-Shub generation scheduler.
package bbs_gen_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SQUARE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEFAULT_MOD  = 40633;   // 179 * 227
    localparam int DEFAULT_SEED = 884;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int grant_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bbs_gen_scheduler_if.sv
// Requester / consumer bundle of the BBS scheduler; master drives requests, slave is the scheduler.
interface bbs_gen_scheduler_if #(
    parameter int NREQ     = 2,
    parameter int SIZE     = 16,
    parameter int OUT_BITS = 256
) ();
    import bbs_gen_scheduler_pkg::*;

    localparam int GRANT_W = grant_width(NREQ);

    logic [NREQ-1:0]     req;
    logic                seed_load;
    logic [SIZE-1:0]     seed_value;
    logic                busy;
    logic [GRANT_W-1:0]  grant_id;
    logic [NREQ-1:0]     ack;
    logic [OUT_BITS-1:0] result;
    logic                result_valid;
    logic                seed_err;
    logic [SIZE-1:0]     bbs_state;

    modport master (
        output req, seed_load, seed_value,
        input  busy, grant_id, ack, result, result_valid, seed_err, bbs_state
    );

    modport slave (
        input  req, seed_load, seed_value,
        output busy, grant_id, ack, result, result_valid, seed_err, bbs_state
    );

endinterface

// File: rtl/bbs_mod_square_seq.sv
// Sequential modular squarer: out = x*x mod MOD, one multiplier bit per cycle, MSB first.
module bbs_mod_square_seq #(
    parameter int SIZE = 16,
    parameter int MOD  = 40633
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SIZE-1:0] x,
    output logic            done,
    output logic [SIZE-1:0] out
);
    localparam logic [SIZE:0] MOD_W = (SIZE+1)'(MOD);
    localparam int            CW    = $clog2(SIZE + 1);

    logic [SIZE:0]   acc_reg;
    logic [SIZE:0]   acc_shift;
    logic [SIZE:0]   acc_add;
    logic [SIZE-1:0] x_reg;
    logic [SIZE-1:0] mult_reg;
    logic [SIZE-1:0] out_reg;
    logic [CW-1:0]   cnt_reg;
    logic            running_reg;
    logic            done_reg;

    // acc stays below MOD < 2^SIZE, so its top bit is always zero before the shift.
    always_comb begin
        acc_shift = {acc_reg[SIZE-1:0], 1'b0};
        if (acc_shift >= MOD_W)
            acc_shift = acc_shift - MOD_W;
        acc_add = acc_shift + (mult_reg[SIZE-1] ? {1'b0, x_reg} : '0);
        if (acc_add >= MOD_W)
            acc_add = acc_add - MOD_W;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg     <= '0;
            x_reg       <= '0;
            mult_reg    <= '0;
            out_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // A start while running simply restarts on the new operand.
                x_reg       <= x;
                mult_reg    <= x;
                acc_reg     <= '0;
                cnt_reg     <= CW'(SIZE);
                running_reg <= 1'b1;
            end else if (running_reg) begin
                acc_reg  <= acc_add;
                mult_reg <= mult_reg << 1;
                cnt_reg  <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    running_reg <= 1'b0;
                    done_reg    <= 1'b1;
                    out_reg     <= acc_add[SIZE-1:0];
                end
            end
        end
    end

    assign done = done_reg;
    assign out  = out_reg;

endmodule

// File: rtl/bbs_gen_scheduler.sv
// Round-robin scheduler sharing one BBS modular squarer among NREQ requesters;
// each grant yields OUT_BITS fresh bits and a one-cycle ack.
module bbs_gen_scheduler
    import bbs_gen_scheduler_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int SIZE     = 16,
    parameter int MOD      = DEFAULT_MOD,
    parameter int OUT_BITS = 256,
    parameter int SEED     = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    bbs_gen_scheduler_if.slave   bus
);
    localparam int GRANT_W = grant_width(NREQ);
    localparam int CNT_W   = $clog2(OUT_BITS + 1);

    state_t              state_reg, state_next;
    logic [GRANT_W-1:0]  grant_reg, grant_next;
    logic [GRANT_W-1:0]  last_reg, last_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [OUT_BITS-1:0] result_reg, result_next;
    logic [SIZE-1:0]     bbs_state_reg, bbs_state_next;
    logic                busy_reg, busy_next;
    logic                seed_err_reg, seed_err_next;

    logic                sq_start;
    logic                sq_done;
    logic [SIZE-1:0]     sq_x;
    logic [SIZE-1:0]     sq_out;
    logic                seed_ok;
    logic                seed_accept;

    // First set request strictly after 'last', wrapping around.
    function automatic logic [GRANT_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                   input logic [GRANT_W-1:0] last);
        logic [GRANT_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && r[GRANT_W'(idx)]) begin
                pick  = GRANT_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Chained iterations feed the fresh product straight back in.
    assign sq_x = (state_reg == ST_SQUARE) ? sq_out : bbs_state_reg;

    bbs_mod_square_seq #(
        .SIZE (SIZE),
        .MOD  (MOD)
    ) u_square (
        .clk   (clk),
        .reset (reset),
        .start (sq_start),
        .x     (sq_x),
        .done  (sq_done),
        .out   (sq_out)
    );

    assign seed_ok     = (bus.seed_value > SIZE'(1)) && (bus.seed_value < SIZE'(MOD));
    assign seed_accept = (state_reg == ST_IDLE) && !(|bus.req) && seed_ok;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        cnt_next       = cnt_reg;
        result_next    = result_reg;
        bbs_state_next = bbs_state_reg;
        busy_next      = busy_reg;
        seed_err_next  = bus.seed_load && !seed_accept;
        sq_start       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_next  = rr_pick(bus.req, last_reg);
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                    result_next = '0;
                    sq_start    = 1'b1;
                    state_next  = ST_SQUARE;
                end else if (bus.seed_load && seed_ok) begin
                    bbs_state_next = bus.seed_value;
                end
            end
            ST_SQUARE: begin
                if (sq_done) begin
                    bbs_state_next = sq_out;
                    result_next    = OUT_BITS'({result_reg, sq_out[0]});
                    cnt_next       = cnt_reg + 1'b1;
                    if (cnt_next == CNT_W'(OUT_BITS))
                        state_next = ST_DONE;
                    else
                        sq_start = 1'b1;
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                last_next  = grant_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            last_reg      <= GRANT_W'(NREQ - 1);
            cnt_reg       <= '0;
            result_reg    <= '0;
            bbs_state_reg <= SIZE'(SEED);
            busy_reg      <= 1'b0;
            seed_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            cnt_reg       <= cnt_next;
            result_reg    <= result_next;
            bbs_state_reg <= bbs_state_next;
            busy_reg      <= busy_next;
            seed_err_reg  <= seed_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ack
            assign bus.ack[gi] = (state_reg == ST_DONE) && (grant_reg == GRANT_W'(gi));
        end
    endgenerate

    assign bus.busy         = busy_reg;
    assign bus.grant_id     = grant_reg;
    assign bus.result       = result_reg;
    assign bus.result_valid = (state_reg == ST_DONE);
    assign bus.seed_err     = seed_err_reg;
    assign bus.bbs_state    = bbs_state_reg;

endmodule

// File: tb/tb_bbs_gen_scheduler.sv
// Scoreboard bench for bbs_gen_scheduler: directed requests, seed loads and resets,
// with a monitor that checks every ack against queued expectations.
module tb_bbs_gen_scheduler;

    localparam int NREQ       = 2;
    localparam int SIZE       = 16;
    localparam int OUT_BITS   = 4;
    localparam int MOD        = 40633;
    localparam int SEED       = 884;
    localparam int RUN_CYCLES = OUT_BITS * (SIZE + 1);
    localparam int ACK_LIMIT  = RUN_CYCLES + 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bbs_gen_scheduler_if #(.NREQ(NREQ), .SIZE(SIZE), .OUT_BITS(OUT_BITS)) bus ();

    bbs_gen_scheduler #(
        .NREQ     (NREQ),
        .SIZE     (SIZE),
        .MOD      (MOD),
        .OUT_BITS (OUT_BITS),
        .SEED     (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                  grant;
        logic [OUT_BITS-1:0] result;
        logic [SIZE-1:0]     state;
    } exp_t;

    exp_t sb_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   busy_cycles = 0;
    int   model_state = SEED;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int bbs_sq(input int x);
        longint p;
        p = longint'(x) * longint'(x);
        return int'(p % MOD);
    endfunction

    task automatic push_exp(input int grant, input logic [OUT_BITS-1:0] res, input int state);
        exp_t e;
        e.grant  = grant;
        e.result = res;
        e.state  = SIZE'(state);
        sb_q.push_back(e);
        model_state = state;
    endtask

    // Continues the reference sequence from model_state for one run.
    task automatic push_run(input int grant);
        logic [OUT_BITS-1:0] res;
        int                  s;
        res = '0;
        s   = model_state;
        for (int i = 0; i < OUT_BITS; i++) begin
            s   = bbs_sq(s);
            res = {res[OUT_BITS-2:0], s[0]};
        end
        push_exp(grant, res, s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < ACK_LIMIT && !seen; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: ack seen=0 within %0d cycles, required 1", name, ACK_LIMIT);
        end
    endtask

    task automatic run_single(input logic [NREQ-1:0] r, input string name);
        bus.req = r;
        wait_ack(name);
        tick();
        bus.req = '0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req       = '0;
        bus.seed_load = 1'b0;
        tick();
        tick();
        reset       = 1'b0;
        model_state = SEED;
    endtask

    task automatic seed_pulse(input logic [SIZE-1:0] v, input logic exp_err,
                              input bit chk_state, input string name);
        bus.seed_value = v;
        bus.seed_load  = 1'b1;
        tick();
        bus.seed_load  = 1'b0;
        @(negedge clk);
        check({name, "_err"}, bus.seed_err, exp_err);
        if (chk_state) check({name, "_state"}, bus.bbs_state, model_state);
        @(negedge clk);
        check({name, "_err_clr"}, bus.seed_err, 0);
    endtask

    // Monitor: every result_valid must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                busy_cycles = 0;
            end else if (bus.result_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: ack=%b with %0d expected entries, required 1",
                             bus.ack, sb_q.size());
                end else begin
                    e = sb_q.pop_front();
                    $display("ack=%b grant=%0d result=0x%h bbs_state=%0d busy_cycles=%0d",
                             bus.ack, bus.grant_id, bus.result, bus.bbs_state, busy_cycles);
                    check("ack_onehot", bus.ack, NREQ'(1) << e.grant);
                    check("grant_id", bus.grant_id, e.grant);
                    check("result", bus.result, e.result);
                    check("bbs_state", bus.bbs_state, e.state);
                    check("run_length", busy_cycles, RUN_CYCLES);
                end
                busy_cycles = 0;
            end else if (bus.busy === 1'b1) begin
                busy_cycles++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.req        = '0;
        bus.seed_load  = 1'b0;
        bus.seed_value = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_result", bus.result, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_seed_err", bus.seed_err, 0);
        check("rst_bbs_state", bus.bbs_state, SEED);

        // Single request from reset: 884 -> 9429, 1037, 18911, 14888, bits 1110.
        push_exp(0, 4'hE, 14888);
        run_single(2'b01, "single_req0");

        // Both held from reset: requester 0 first, then alternating, one continuous sequence.
        do_reset();
        push_exp(0, 4'hE, 14888);
        push_run(1);
        push_run(0);
        push_run(1);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) wait_ack("rr_both");
        tick();
        bus.req = '0;

        // Reseed to 884 in IDLE, then requester 1 alone.
        model_state = SEED;
        seed_pulse(16'd884, 1'b0, 1'b1, "seed_ok");
        push_exp(1, 4'hE, 14888);
        run_single(2'b10, "reseed_req1");

        // Out-of-range seeds are rejected and leave the state untouched.
        seed_pulse(16'd0, 1'b1, 1'b1, "seed_zero");
        seed_pulse(16'd40633, 1'b1, 1'b1, "seed_mod");
        seed_pulse(16'd1, 1'b1, 1'b1, "seed_one");

        // Seed load coinciding with a grant, and another during the run.
        push_run(0);
        bus.req        = 2'b01;
        bus.seed_value = 16'd1000;
        bus.seed_load  = 1'b1;
        tick();
        bus.seed_load  = 1'b0;
        @(negedge clk);
        check("seed_vs_grant_err", bus.seed_err, 1);
        repeat (10) tick();
        seed_pulse(16'd2000, 1'b1, 1'b0, "seed_busy");
        wait_ack("seed_busy_run");
        tick();
        bus.req = '0;

        // Request withdrawn mid-run: the run still completes with its ack.
        push_run(0);
        bus.req = 2'b01;
        repeat (20) tick();
        bus.req = '0;
        wait_ack("drop_req0");
        @(negedge clk);
        check("drop_idle_busy", bus.busy, 0);

        // Reset mid-run aborts without an ack.
        bus.req = 2'b01;
        repeat (30) tick();
        do_reset();
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_bbs_state", bus.bbs_state, SEED);
        check("abort_result", bus.result, 0);
        check("abort_ack", bus.ack, 0);
        repeat (RUN_CYCLES + 20) tick();
        push_exp(0, 4'hE, 14888);
        run_single(2'b01, "after_abort");

        repeat (5) tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
